// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the float add/sub arbiter.
// Optional result flags are enabled with FP_ARB_FLAGS_EN.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int FLAG_W   = 5;

  localparam int FLAG_NAN      = 4;
  localparam int FLAG_POS_INF  = 3;
  localparam int FLAG_NEG_INF  = 2;
  localparam int FLAG_POS_ZERO = 1;
  localparam int FLAG_NEG_ZERO = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request
// strictly after ptr, wrapping around.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int k;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any       = 1'b1;
        winner[k] = 1'b1;
        idx       = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one combinational float add/sub unit among NUM_REQ requesters.
// Define FP_ARB_FLAGS_EN to register and return the unit's class flags.
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [31:0]             fa_a,
  output logic [31:0]             fa_b,
  input  logic [31:0]             fa_out
`ifdef FP_ARB_FLAGS_EN
  ,
  input  logic                    fa_nan,
  input  logic                    fa_pos_inf,
  input  logic                    fa_neg_inf,
  input  logic                    fa_pos_zero,
  input  logic                    fa_neg_zero,
  output logic [FLAG_W-1:0]       rsp_flags
`endif
);

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id;
  logic [ID_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_any;
  logic                fire;
  logic [FP_W-1:0]     op_a;
  logic [FP_W-1:0]     op_b;
  logic [FP_W-1:0]     sel_a;
  logic [FP_W-1:0]     sel_b;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign fire  = (state != EXEC) && win_any;
  assign sel_a = req_a[int'(win_idx)*FP_W +: FP_W];
  assign sel_b = req_b[int'(win_idx)*FP_W +: FP_W];
  assign fa_a  = op_a;
  assign fa_b  = op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE, DONE: state_nxt = win_any ? EXEC : IDLE;
      EXEC:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    busy      = (state == EXEC);
    if (rst_n && fire)   gnt = win_oh;
    if (state == DONE)   rsp_valid = NUM_REQ'(1) << rsp_id;
  end

  // Subtraction is folded into operand B as a sign flip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      id       <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      if (fire) begin
        op_a <= sel_a;
        op_b <= {sel_b[SIGN_BIT] ^ req_sub[win_idx],
                 sel_b[SIGN_BIT-1:0]};
        id   <= win_idx;
        ptr  <= win_idx;
      end
      if (state == EXEC) begin
        rsp_data <= fa_out;
        rsp_id   <= id;
      end
    end
  end

`ifdef FP_ARB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_flags <= '0;
    end else if (state == EXEC) begin
      rsp_flags[FLAG_NAN]      <= fa_nan;
      rsp_flags[FLAG_POS_INF]  <= fa_pos_inf;
      rsp_flags[FLAG_NEG_INF]  <= fa_neg_inf;
      rsp_flags[FLAG_POS_ZERO] <= fa_pos_zero;
      rsp_flags[FLAG_NEG_ZERO] <= fa_neg_zero;
    end
  end
`endif

endmodule
